// File: rtl/vr_udp_tx_arbiter.sv
// -----------------------------------------------------------------------------
// vr_udp_pkg / vr_udp_tx_arbiter
//
// Purpose
//   Packet-level round-robin arbiter that shares the single UDP TX path
//   (meta channel + data channel) among NUM_SRC VR engines (setup, prepare,
//   commit, ...). One source is granted per packet. Its udp_info is forwarded
//   on the meta channel, then its data beats stream through until the beat
//   flagged last is taken downstream. It sits between the VR engines and the
//   UDP TX formatter.
//
//   The datapath is a pure combinational mux selected by grant_reg. Nothing is
//   buffered, so no beat latency is added. The only sequential state is the
//   arbitration FSM, the latched grant and the round-robin pointer.
//
// Parameters
//   NOC_DATA_W      data beat width in bits. Must be overridden with a
//                   multiple of 8.
//   NOC_PADBYTES_W  width of the padbytes field, $clog2(NOC_DATA_W/8).
//   NUM_SRC         number of requesting engines, >= 2.
//   SRC_W           grant index width, $clog2(NUM_SRC).
//
// Ports
//   clk                 clock
//   rst                 synchronous active-high reset
//   src_meta_val  [N]   per-source packet request / meta valid
//   src_meta_info [N]   per-source header info (udp_info_t)
//   src_meta_rdy  [N]   per-source meta accept
//   src_data_val  [N]   per-source data valid
//   src_data      [N]   per-source data beat
//   src_data_pad  [N]   per-source padbytes (meaningful on the last beat)
//   src_data_last [N]   per-source last-beat flag
//   src_data_rdy  [N]   per-source data accept
//   arb_udp_meta_val / arb_udp_meta_info / udp_arb_meta_rdy
//                       meta channel towards the UDP TX formatter
//   arb_udp_data_val / arb_udp_data / arb_udp_data_pad / arb_udp_data_last /
//   udp_arb_data_rdy    data channel towards the UDP TX formatter
//   arb_busy            high whenever a packet is granted (state != IDLE)
// -----------------------------------------------------------------------------

package vr_udp_pkg;

  // Header fields handed from a VR engine to the UDP TX formatter.
  typedef struct packed {
    logic [31:0] src_ip;
    logic [31:0] dst_ip;
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [15:0] data_len;
  } udp_info_t;

endpackage

module vr_udp_tx_arbiter
  import vr_udp_pkg::*;
#(
  parameter int NOC_DATA_W     = -1,
  parameter int NOC_PADBYTES_W = $clog2(NOC_DATA_W / 8),
  parameter int NUM_SRC        = 4,
  parameter int SRC_W          = $clog2(NUM_SRC)
) (
  input  logic                      clk,
  input  logic                      rst,

  // Engine side, meta channel
  input  logic [NUM_SRC-1:0]        src_meta_val,
  input  udp_info_t                 src_meta_info [NUM_SRC],
  output logic [NUM_SRC-1:0]        src_meta_rdy,

  // Engine side, data channel
  input  logic [NUM_SRC-1:0]        src_data_val,
  input  logic [NOC_DATA_W-1:0]     src_data      [NUM_SRC],
  input  logic [NOC_PADBYTES_W-1:0] src_data_pad  [NUM_SRC],
  input  logic [NUM_SRC-1:0]        src_data_last,
  output logic [NUM_SRC-1:0]        src_data_rdy,

  // UDP TX formatter side, meta channel
  output logic                      arb_udp_meta_val,
  output udp_info_t                 arb_udp_meta_info,
  input  logic                      udp_arb_meta_rdy,

  // UDP TX formatter side, data channel
  output logic                      arb_udp_data_val,
  output logic [NOC_DATA_W-1:0]     arb_udp_data,
  output logic [NOC_PADBYTES_W-1:0] arb_udp_data_pad,
  output logic                      arb_udp_data_last,
  input  logic                      udp_arb_data_rdy,

  output logic                      arb_busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    META = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t           state;
  logic [SRC_W-1:0] grant_reg;
  logic [SRC_W-1:0] rr_ptr;

  logic             scan_hit;
  logic [SRC_W-1:0] scan_idx;
  logic [SRC_W-1:0] cand;
  logic [SRC_W-1:0] next_ptr;

  logic             meta_xfer;
  logic             data_xfer;
  logic             last_xfer;

  // ---------------------------------------------------------------------------
  // Round-robin scan. Requests are visited in the order rr_ptr, rr_ptr+1, ...
  // with wrap modulo NUM_SRC. The first set bit wins. The modulo is done on a
  // plain int so that non-power-of-two NUM_SRC wraps at NUM_SRC and not at
  // 2**SRC_W.
  // ---------------------------------------------------------------------------
  always_comb begin
    scan_hit = 1'b0;
    scan_idx = rr_ptr;
    cand     = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      cand = SRC_W'((int'(rr_ptr) + i) % NUM_SRC);
      if (!scan_hit && src_meta_val[cand]) begin
        scan_hit = 1'b1;
        scan_idx = cand;
      end
    end
  end

  // The pointer moves to the source after the one just served. This makes
  // the just-served source the lowest priority for the next packet.
  assign next_ptr = (grant_reg == SRC_W'(NUM_SRC - 1)) ? '0 : grant_reg + SRC_W'(1);

  // Handshakes are qualified by the granted source only. The grant is frozen
  // for the whole packet, whatever other requests do.
  assign meta_xfer = src_meta_val[grant_reg] && udp_arb_meta_rdy;
  assign data_xfer = src_data_val[grant_reg] && udp_arb_data_rdy;
  assign last_xfer = data_xfer && src_data_last[grant_reg];

  // ---------------------------------------------------------------------------
  // Arbitration FSM
  //   IDLE: pick a winner and latch it. Nothing is driven towards either side.
  //   META: forward the winner's header until the formatter takes it.
  //   DATA: stream the winner's beats until the last one is taken.
  // Leaving DATA always passes through IDLE, so back-to-back packets cost one
  // bubble cycle. That cycle is where the next winner is chosen.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      grant_reg <= '0;
      rr_ptr    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (scan_hit) begin
            grant_reg <= scan_idx;
            state     <= META;
          end
        end
        META: begin
          if (meta_xfer) begin
            state <= DATA;
          end
        end
        DATA: begin
          if (last_xfer) begin
            state  <= IDLE;
            rr_ptr <= next_ptr;
          end
        end
        default: begin
          state <= state_t'(2'bxx);
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Handshake steering. Only the granted source ever sees a ready, and only
  // in the channel that matches the current phase. Data offered early, during
  // META, is therefore neither forwarded nor accepted.
  // ---------------------------------------------------------------------------
  always_comb begin
    src_meta_rdy     = '0;
    src_data_rdy     = '0;
    arb_udp_meta_val = 1'b0;
    arb_udp_data_val = 1'b0;
    case (state)
      IDLE: begin
      end
      META: begin
        arb_udp_meta_val        = src_meta_val[grant_reg];
        src_meta_rdy[grant_reg] = udp_arb_meta_rdy;
      end
      DATA: begin
        arb_udp_data_val        = src_data_val[grant_reg];
        src_data_rdy[grant_reg] = udp_arb_data_rdy;
      end
      default: begin
        src_meta_rdy     = 'x;
        src_data_rdy     = 'x;
        arb_udp_meta_val = 1'bx;
        arb_udp_data_val = 1'bx;
      end
    endcase
  end

  // Payload is muxed by the latched grant at all times. The valids above
  // decide whether the formatter may look at it.
  assign arb_udp_meta_info = src_meta_info[grant_reg];
  assign arb_udp_data      = src_data[grant_reg];
  assign arb_udp_data_pad  = src_data_pad[grant_reg];
  assign arb_udp_data_last = src_data_last[grant_reg];

  assign arb_busy = (state != IDLE);

endmodule

// File: tb/tb_vr_udp_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vr_udp_tx_arbiter
//   Directed cycle table for the short corner cases, followed by scoreboarded
//   packet traffic. In the traffic runs each engine owns a queue of generated
//   packets. A packet-level model predicts which source owns the TX path, what
//   the formatter must see, and which ready each engine must get.
// -----------------------------------------------------------------------------
module tb_vr_udp_tx_arbiter;
  import vr_udp_pkg::*;

  localparam int NSRC   = 4;
  localparam int DW     = 64;
  localparam int PW     = 3;
  localparam int BUDGET = 6000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NSRC-1:0] src_meta_val;
  udp_info_t       src_meta_info [NSRC];
  logic [NSRC-1:0] src_meta_rdy;
  logic [NSRC-1:0] src_data_val;
  logic [DW-1:0]   src_data      [NSRC];
  logic [PW-1:0]   src_data_pad  [NSRC];
  logic [NSRC-1:0] src_data_last;
  logic [NSRC-1:0] src_data_rdy;
  logic            arb_udp_meta_val;
  udp_info_t       arb_udp_meta_info;
  logic            udp_arb_meta_rdy;
  logic            arb_udp_data_val;
  logic [DW-1:0]   arb_udp_data;
  logic [PW-1:0]   arb_udp_data_pad;
  logic            arb_udp_data_last;
  logic            udp_arb_data_rdy;
  logic            arb_busy;

  vr_udp_tx_arbiter #(
    .NOC_DATA_W (DW),
    .NUM_SRC    (NSRC)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .src_meta_val      (src_meta_val),
    .src_meta_info     (src_meta_info),
    .src_meta_rdy      (src_meta_rdy),
    .src_data_val      (src_data_val),
    .src_data          (src_data),
    .src_data_pad      (src_data_pad),
    .src_data_last     (src_data_last),
    .src_data_rdy      (src_data_rdy),
    .arb_udp_meta_val  (arb_udp_meta_val),
    .arb_udp_meta_info (arb_udp_meta_info),
    .udp_arb_meta_rdy  (udp_arb_meta_rdy),
    .arb_udp_data_val  (arb_udp_data_val),
    .arb_udp_data      (arb_udp_data),
    .arb_udp_data_pad  (arb_udp_data_pad),
    .arb_udp_data_last (arb_udp_data_last),
    .udp_arb_data_rdy  (udp_arb_data_rdy),
    .arb_busy          (arb_busy)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- directed cycle table ----------------
  typedef struct {
    logic            rst;
    logic [NSRC-1:0] mv, dv, dl;
    logic            mr, dr;
    logic            e_mv, e_dv, e_dl, e_busy;
    logic [NSRC-1:0] e_smr, e_sdr;
    int              e_src;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic [3:0] mv, input logic [3:0] dv, input logic [3:0] dl,
                     input logic mr, input logic dr, input logic e_mv, input logic e_dv,
                     input logic e_dl, input logic e_busy, input logic [3:0] e_smr,
                     input logic [3:0] e_sdr, input int e_src);
    vec_t v;
    v.rst = r; v.mv = mv; v.dv = dv; v.dl = dl; v.mr = mr; v.dr = dr;
    v.e_mv = e_mv; v.e_dv = e_dv; v.e_dl = e_dl; v.e_busy = e_busy;
    v.e_smr = e_smr; v.e_sdr = e_sdr; v.e_src = e_src;
    tbl.push_back(v);
  endtask

  function automatic udp_info_t info_c(input int s);
    udp_info_t u;
    u.src_ip   = 32'hC0A8_0000 + 32'(s);
    u.dst_ip   = 32'h0A00_0100 + 32'(s);
    u.src_port = 16'h1000 + 16'(s);
    u.dst_port = 16'h2000 + 16'(s);
    u.data_len = 16'h0040 + 16'(s);
    return u;
  endfunction

  function automatic logic [DW-1:0] data_c(input int s);
    return 64'hD0D0_5A5A_0000_0000 | 64'(s);
  endfunction

  function automatic logic [PW-1:0] pad_c(input int s);
    return (s == 1) ? 3'd7 : 3'(s);
  endfunction

  function automatic logic [10:0] ctl_now();
    return {arb_udp_meta_val, arb_udp_data_val, arb_busy, src_meta_rdy, src_data_rdy};
  endfunction

  task automatic do_reset();
    rst              = 1'b1;
    src_meta_val     = '0;
    src_data_val     = '0;
    src_data_last    = '0;
    udp_arb_meta_rdy = 1'b0;
    udp_arb_data_rdy = 1'b0;
    for (int s = 0; s < NSRC; s++) begin
      src_meta_info[s] = info_c(s);
      src_data[s]      = data_c(s);
      src_data_pad[s]  = pad_c(s);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_ctl", 256'(ctl_now()), 256'(0));
  endtask

  // ---------------- packet traffic with reference model ----------------
  typedef struct {
    udp_info_t     info;
    int            n;
    logic [DW-1:0] base;
    logic [PW-1:0] pad;
  } pkt_t;

  pkt_t pq  [NSRC][$];   // stimulus side: packets still to be offered
  pkt_t exq [NSRC][$];   // model side: packets still expected downstream
  int   sst  [NSRC];     // 0 waiting, 1 request raised, 2 header taken
  int   bi   [NSRC];
  int   gapc [NSRC];
  int   grant_log[$];

  function automatic logic [DW-1:0] beat_val(input pkt_t p, input int k);
    return p.base + 64'(k) * 64'h0001_0001_0001_0001;
  endfunction

  // First requester at or after ptr, going round modulo NSRC.
  function automatic int rr_pick(input int ptr, input logic [NSRC-1:0] req);
    for (int k = 0; k < NSRC; k++) begin
      int idx;
      idx = (ptr + k) % NSRC;
      if (req[2'(idx)]) return idx;
    end
    return 0;
  endfunction

  task automatic run_traffic(input int npkt, input int fixed_beats, input bit gaps,
                             input int rdymode, input logic [NSRC-1:0] mask);
    int              ph, own, ptr, mb, cyc;
    bit              done;
    logic [NSRC-1:0] mtak, dtak;
    logic [10:0]     exp_ctl;
    logic            e_mv, e_dv;
    logic [NSRC-1:0] e_smr, e_sdr;
    pkt_t            p;

    grant_log.delete();
    for (int s = 0; s < NSRC; s++) begin
      pq[s].delete();
      exq[s].delete();
      sst[s]  = 0;
      bi[s]   = 0;
      gapc[s] = gaps ? int'($urandom % 4) : 0;
      if (mask[s]) begin
        for (int k = 0; k < npkt; k++) begin
          p.info = {$urandom, $urandom, 16'($urandom), 16'($urandom), 16'(k)};
          p.n    = (fixed_beats > 0) ? fixed_beats : 1 + int'($urandom % 4);
          p.base = {$urandom, $urandom};
          p.pad  = 3'($urandom);
          pq[s].push_back(p);
          exq[s].push_back(p);
        end
      end
    end

    ph = 0; own = 0; ptr = 0; mb = 0; done = 1'b0;
    mtak = '0; dtak = '0;
    for (cyc = 0; cyc < BUDGET && !done; cyc++) begin
      @(posedge clk);
      #1;
      // engines react to what was taken at the edge just passed
      for (int s = 0; s < NSRC; s++) begin
        if (mtak[s]) begin
          src_meta_val[s] = 1'b0;
          sst[s] = 2;
        end
        if (dtak[s] && pq[s].size() > 0) begin
          src_data_val[s] = 1'b0;
          if (bi[s] == pq[s][0].n - 1) begin
            void'(pq[s].pop_front());
            sst[s]  = 0;
            bi[s]   = 0;
            gapc[s] = gaps ? int'($urandom % 4) : 0;
          end else begin
            bi[s]++;
          end
        end
        if (sst[s] == 0 && pq[s].size() > 0) begin
          if (gapc[s] > 0) gapc[s]--;
          else begin
            sst[s]           = 1;
            src_meta_val[s]  = 1'b1;
            src_meta_info[s] = pq[s][0].info;
          end
        end
        if (sst[s] != 0 && !src_data_val[s] && (!gaps || ($urandom % 3) != 0)) begin
          src_data_val[s]  = 1'b1;
          src_data[s]      = beat_val(pq[s][0], bi[s]);
          src_data_last[s] = (bi[s] == pq[s][0].n - 1);
          src_data_pad[s]  = src_data_last[s] ? pq[s][0].pad : '0;
        end
      end
      case (rdymode)
        1:       begin udp_arb_meta_rdy = 1'b1; udp_arb_data_rdy = 1'b1; end
        2:       begin udp_arb_meta_rdy = (cyc >= 5); udp_arb_data_rdy = cyc[0]; end
        default: begin
          udp_arb_meta_rdy = ($urandom % 2) == 0;
          udp_arb_data_rdy = ($urandom % 3) != 0;
        end
      endcase

      @(negedge clk);
      // what the formatter and the engines must see this cycle
      e_mv  = (ph == 1) ? src_meta_val[own] : 1'b0;
      e_dv  = (ph == 2) ? src_data_val[own] : 1'b0;
      e_smr = (ph == 1 && udp_arb_meta_rdy) ? 4'(1 << own) : '0;
      e_sdr = (ph == 2 && udp_arb_data_rdy) ? 4'(1 << own) : '0;
      exp_ctl = {e_mv, e_dv, (ph != 0), e_smr, e_sdr};
      chk("rnd_ctl", 256'(ctl_now()), 256'(exp_ctl));
      if (ph == 1 && exq[own].size() > 0)
        chk("rnd_info", 256'(arb_udp_meta_info), 256'(exq[own][0].info));
      mtak = src_meta_val & src_meta_rdy;
      dtak = src_data_val & src_data_rdy;

      // packet-level progress for the coming edge
      case (ph)
        0: if (|src_meta_val) begin
             own = rr_pick(ptr, src_meta_val);
             ph  = 1;
           end
        1: if (src_meta_val[own] && udp_arb_meta_rdy) begin
             ph = 2;
             mb = 0;
           end
        default: if (src_data_val[own] && udp_arb_data_rdy && exq[own].size() > 0) begin
             p = exq[own][0];
             chk("rnd_beat", 256'({arb_udp_data, arb_udp_data_pad, arb_udp_data_last}),
                 256'({beat_val(p, mb), (mb == p.n - 1) ? p.pad : 3'd0, (mb == p.n - 1)}));
             if (mb == p.n - 1) begin
               void'(exq[own].pop_front());
               grant_log.push_back(own);
               ptr = (own + 1) % NSRC;
               ph  = 0;
             end else begin
               mb++;
             end
           end
      endcase

      done = (ph == 0);
      for (int s = 0; s < NSRC; s++) if (exq[s].size() > 0) done = 1'b0;
    end
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL traffic_timeout: %0d packets outstanding after %0d cycles, required 0",
               exq[0].size() + exq[1].size() + exq[2].size() + exq[3].size(), BUDGET);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    //  rst mv      dv      dl      mr dr  emv edv edl bsy esmr    esdr    src
    add(0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0);
    // single-beat packet from source 1, full padding
    add(0, 4'b0010, 4'b0010, 4'b0010, 1, 1, 0, 0, 0, 0, 4'b0000, 4'b0000, 1);
    add(0, 4'b0010, 4'b0010, 4'b0010, 1, 1, 1, 0, 0, 1, 4'b0010, 4'b0000, 1);
    add(0, 4'b0000, 4'b0010, 4'b0010, 1, 1, 0, 1, 1, 1, 4'b0000, 4'b0010, 1);
    add(0, 4'b0000, 4'b0000, 4'b0000, 1, 1, 0, 0, 0, 0, 4'b0000, 4'b0000, 0);
    add(1, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0);
    // sources 0 and 2 together from pointer 0: source 0 first
    add(0, 4'b0101, 4'b0000, 4'b0000, 1, 1, 0, 0, 0, 0, 4'b0000, 4'b0000, 0);
    add(0, 4'b0101, 4'b0001, 4'b0000, 1, 1, 1, 0, 0, 1, 4'b0001, 4'b0000, 0);
    add(0, 4'b0100, 4'b0001, 4'b0000, 1, 1, 0, 1, 0, 1, 4'b0000, 4'b0001, 0);
    add(0, 4'b0100, 4'b0001, 4'b0001, 1, 1, 0, 1, 1, 1, 4'b0000, 4'b0001, 0);
    add(0, 4'b0100, 4'b0000, 4'b0000, 1, 1, 0, 0, 0, 0, 4'b0000, 4'b0000, 0);
    // source 2 with early data while its header is stalled
    add(0, 4'b0100, 4'b0100, 4'b0100, 0, 1, 1, 0, 0, 1, 4'b0000, 4'b0000, 2);
    add(0, 4'b0100, 4'b0100, 4'b0100, 1, 1, 1, 0, 0, 1, 4'b0100, 4'b0000, 2);
    add(0, 4'b0000, 4'b0100, 4'b0100, 1, 0, 0, 1, 1, 1, 4'b0000, 4'b0000, 2);
    add(0, 4'b0000, 4'b0100, 4'b0100, 1, 1, 0, 1, 1, 1, 4'b0000, 4'b0100, 2);
    add(0, 4'b0000, 4'b0000, 4'b0000, 1, 1, 0, 0, 0, 0, 4'b0000, 4'b0000, 0);
    // pointer now 3: all requesting, source 3 wins
    add(0, 4'b1111, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0);
    add(0, 4'b1111, 4'b0000, 4'b0000, 1, 0, 1, 0, 0, 1, 4'b1000, 4'b0000, 3);
    // reset in DATA: back to IDLE and pointer 0
    add(1, 4'b1111, 4'b0000, 4'b0000, 1, 0, 0, 0, 0, 1, 4'b0000, 4'b0000, 3);
    add(0, 4'b1111, 4'b0000, 4'b0000, 1, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0);
    add(0, 4'b1111, 4'b0000, 4'b0000, 0, 0, 1, 0, 0, 1, 4'b0000, 4'b0000, 0);
    add(1, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 1, 4'b0000, 4'b0000, 0);
    add(0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0);

    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk);
      #1;
      rst              = tbl[i].rst;
      src_meta_val     = tbl[i].mv;
      src_data_val     = tbl[i].dv;
      src_data_last    = tbl[i].dl;
      udp_arb_meta_rdy = tbl[i].mr;
      udp_arb_data_rdy = tbl[i].dr;
      @(negedge clk);
      chk($sformatf("tbl%0d_ctl", i), 256'(ctl_now()),
          256'({tbl[i].e_mv, tbl[i].e_dv, tbl[i].e_busy, tbl[i].e_smr, tbl[i].e_sdr}));
      if (tbl[i].e_mv)
        chk($sformatf("tbl%0d_info", i), 256'(arb_udp_meta_info), 256'(info_c(tbl[i].e_src)));
      if (tbl[i].e_dv)
        chk($sformatf("tbl%0d_beat", i),
            256'({arb_udp_data, arb_udp_data_pad, arb_udp_data_last}),
            256'({data_c(tbl[i].e_src), pad_c(tbl[i].e_src), tbl[i].e_dl}));
    end

    // all four engines saturating with 3-beat packets: strict rotation
    do_reset();
    run_traffic(3, 3, 1'b0, 1, 4'b1111);
    chk("rr_count", 256'(grant_log.size()), 256'(12));
    for (int k = 0; k < 12; k++) begin
      int g;
      g = (k < grant_log.size()) ? grant_log[k] : 99;
      chk($sformatf("rr_order%0d", k), 256'(g), 256'(k % 4));
    end

    // header stalled 5 cycles, then toggling data ready
    do_reset();
    run_traffic(2, 4, 1'b0, 2, 4'b0100);

    // random traffic, random gaps and backpressure
    do_reset();
    run_traffic(12, 0, 1'b1, 0, 4'b1111);
    do_reset();
    run_traffic(8, 0, 1'b1, 0, 4'b1011);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
